mux41_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one DW-bit 4:1 mux output channel among four valid/ready requesters. It drives the mux select, steers the selected requester's data to the output, and routes downstream `out_ready` back to the granted requester only. It sits between four producers and a single consumer.

---
 rtl/mux41_rr_arbiter_pkg.sv | 20 ++
 rtl/mux41_rr_arbiter_if.sv | 42 ++++
 rtl/mux41_rr_arbiter_rr_pick4.sv | 32 +++
 rtl/mux41_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux41_rr_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mux41_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux41_arb_pkg
// Shared definitions for the 4:1 round-robin mux arbiter slice.
//   arb_state_t              : FSM state enum (IDLE, GRANT)
//   MUX41_ARB_N              : number of requesters
//   MUX41_ARB_DW_DEF         : default data width
//   MUX41_ARB_BURST_MAX_DEF  : default maximum beats per grant (burst build)
// ---------------------------------------------------------------------------
package mux41_arb_pkg;

    localparam int MUX41_ARB_N             = 4;
    localparam int MUX41_ARB_DW_DEF        = 2;
    localparam int MUX41_ARB_BURST_MAX_DEF = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux41_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux41_rr_arbiter_if
// Bundles the four requester channels, the shared output channel and the
// arbiter status signals.
//   in_valid[3:0], in_data0..3 : requester side (driven by producers)
//   in_ready[3:0]              : per-requester ready (one-hot or zero)
//   out_valid, out_data        : muxed output channel
//   out_ready                  : downstream ready
//   sel, busy                  : registered select and GRANT indicator
// Handshake semantics (all channels): a beat transfers on a rising clk edge
// where valid and ready are both high; valid does not depend on ready.
// Modports:
//   master : producer/consumer side (testbench or surrounding logic)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface mux41_rr_arbiter_if
    import mux41_arb_pkg::*;
#(
    parameter int DW = MUX41_ARB_DW_DEF
);
    logic [MUX41_ARB_N-1:0] in_valid;
    logic [DW-1:0]          in_data0;
    logic [DW-1:0]          in_data1;
    logic [DW-1:0]          in_data2;
    logic [DW-1:0]          in_data3;
    logic [MUX41_ARB_N-1:0] in_ready;
    logic                   out_valid;
    logic [DW-1:0]          out_data;
    logic                   out_ready;
    logic [1:0]             sel;
    logic                   busy;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, sel, busy
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, sel, busy
    );
endinterface

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker: returns the first set bit of req when
// scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//   req[3:0] : request vector
//   ptr[1:0] : highest-priority index
//   found    : any request set
//   idx[1:0] : chosen index (equals ptr when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);
    logic [1:0] cand;

    // Scan from the farthest offset down to offset 0 so the closest
    // request to ptr is the last (winning) assignment.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/mux41_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux41_rr_arbiter
// Round-robin arbiter sharing one DW-bit 4:1 mux output among four
// valid/ready requesters. Grants are registered (sel); data, out_valid and
// in_ready are combinational from sel/state and the current inputs.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux41_rr_arbiter_if.slave (requesters, output channel, sel, busy)
// Parameters:
//   DW        : data width
//   BURST_MAX : max beats per grant in burst build (1..15)
// Build option:
//   MUX41_ARB_BURST_EN defined   -> keep the grant for up to BURST_MAX beats
//   MUX41_ARB_BURST_EN undefined -> release after every beat
// ---------------------------------------------------------------------------
module mux41_rr_arbiter
    import mux41_arb_pkg::*;
#(
    parameter int DW        = MUX41_ARB_DW_DEF,
    parameter int BURST_MAX = MUX41_ARB_BURST_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux41_rr_arbiter_if.slave    bus
);
    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_GRANT = 1'(GRANT);

    if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst_max
        $error("mux41_rr_arbiter: BURST_MAX out of range 1..15");
    end

    logic [0:0]  state;
    logic [1:0]  sel_q;
    logic [1:0]  ptr_q;
    logic        found;
    logic [1:0]  pick_idx;
    logic        granted;
    logic        cur_valid;
    logic        hs;
    logic        release_now;

    assign granted   = (state == ST_GRANT);
    assign cur_valid = bus.in_valid[sel_q];
    assign hs        = granted & cur_valid & bus.out_ready;

`ifdef MUX41_ARB_BURST_EN
    localparam logic [3:0] BEAT_LAST = 4'(BURST_MAX - 1);
    logic [3:0] beat_cnt;

    // A requester that drops valid mid-burst is caught by the withdrawal
    // path on the following cycle, so only the beat limit releases here.
    assign release_now = hs & (beat_cnt == BEAT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= 4'd0;
        end else if (!granted || !cur_valid || release_now) begin
            beat_cnt <= 4'd0;
        end else if (hs) begin
            beat_cnt <= beat_cnt + 4'd1;
        end
    end
`else
    assign release_now = hs;
`endif

    rr_pick4 u_pick (
        .req   (bus.in_valid),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sel_q <= 2'd0;
            ptr_q <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        sel_q <= pick_idx;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Withdrawal and release both hand priority to the next
                    // requester after the current one.
                    if (!cur_valid || release_now) begin
                        ptr_q <= sel_q + 2'd1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Key/value mux keyed on sel: each key selects its requester's data.
    logic [DW-1:0] data_arr [MUX41_ARB_N];
    assign data_arr[0] = bus.in_data0;
    assign data_arr[1] = bus.in_data1;
    assign data_arr[2] = bus.in_data2;
    assign data_arr[3] = bus.in_data3;

    always_comb begin
        bus.out_data = data_arr[0];
        for (int k = 0; k < MUX41_ARB_N; k++) begin
            if (sel_q == 2'(k)) begin
                bus.out_data = data_arr[k];
            end
        end
    end

    assign bus.out_valid = granted & cur_valid;
    assign bus.in_ready  = granted ? (4'({3'b000, bus.out_ready}) << sel_q) : 4'b0000;
    assign bus.sel       = sel_q;
    assign bus.busy      = granted;
endmodule

// File: tb/tb_mux41_rr_arbiter.sv
module tb_mux41_rr_arbiter;
  localparam int DW        = 2;
  localparam int BURST_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mux41_rr_arbiter_if #(.DW(DW)) bus ();

  mux41_rr_arbiter #(.DW(DW), .BURST_MAX(BURST_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int hs_exp   = 0;
  int hs_seen  = 0;
  logic [DW+1:0] exp_q[$];

  // Reference model: who holds the grant (-1 = nobody), rotating priority,
  // last granted index, beats delivered in the current grant.
  int m_g     = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_beats = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] get_data(input int i);
    case (i)
      0: return bus.in_data0;
      1: return bus.in_data1;
      2: return bus.in_data2;
      default: return bus.in_data3;
    endcase
  endfunction

  function automatic bit release_due(input int beats);
`ifdef MUX41_ARB_BURST_EN
    return beats >= BURST_MAX;
`else
    return beats >= 1;
`endif
  endfunction

  // Advance the model over one active edge using the inputs held during it.
  task automatic model_update();
    bit got;
    int c;
    if (m_g < 0) begin
      got = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!got && bus.in_valid[c]) begin
          got   = 1;
          m_g   = c;
          m_sel = c;
        end
      end
    end else if (!bus.in_valid[m_g]) begin
      m_ptr   = (m_g + 1) % 4;
      m_g     = -1;
      m_beats = 0;
    end else if (bus.out_ready) begin
      m_beats++;
      if (release_due(m_beats)) begin
        m_ptr   = (m_g + 1) % 4;
        m_g     = -1;
        m_beats = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] v, input logic r);
    bus.in_valid  = v;
    bus.out_ready = r;
    bus.in_data0  = DW'($urandom);
    bus.in_data1  = DW'($urandom);
    bus.in_data2  = DW'($urandom);
    bus.in_data3  = DW'($urandom);
  endtask

  task automatic step(input logic [3:0] v, input logic r);
    logic exp_ov;
    logic [3:0] exp_ir;
    @(posedge clk);
    #1;
    model_update();
    check("sel", 32'(bus.sel), 32'(m_sel));
    check("busy", 32'(bus.busy), 32'(m_g >= 0));
    drive(v, r);
    #1;
    exp_ov = (m_g >= 0) && bus.in_valid[m_g];
    exp_ir = (m_g >= 0 && r) ? 4'(1 << m_g) : 4'b0000;
    check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    check("in_ready", 32'(bus.in_ready), 32'(exp_ir));
    if (exp_ov && r) begin
      exp_q.push_back({2'(m_g), get_data(m_g)});
      hs_exp++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    if (rst_n) model_update();
    drive(4'hF, 1'b1);
    #1;
    rst_n   = 1'b0;
    m_g     = -1;
    m_ptr   = 0;
    m_sel   = 0;
    m_beats = 0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_sel", 32'(bus.sel), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic rand_phase(input int n, input int pv, input int pr);
    logic [3:0] v;
    logic r;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 99) < pv);
      r = ($urandom_range(0, 99) < pr);
      step(v, r);
    end
  endtask

  // ---------------- monitor ----------------
  logic [DW+1:0] got_beat;
  logic [DW+1:0] want_beat;
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      hs_seen++;
      got_beat = {bus.sel, bus.out_data};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat: got unexpected beat %0h expected none at %0t", got_beat, $time);
      end else begin
        want_beat = exp_q.pop_front();
        check("beat", 32'(got_beat), 32'(want_beat));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    drive(4'hF, 1'b1);
    do_reset();

    // fairness: everyone requesting, consumer always ready
    repeat (10) step(4'hF, 1'b1);

    // single requester 2, then all requesting
    repeat (3) step(4'b0100, 1'b1);
    repeat (3) step(4'hF, 1'b1);

    // backpressure on requester 1, then release
    repeat (4) step(4'b0010, 1'b0);
    repeat (3) step(4'b0010, 1'b1);

    // withdrawal by requester 3 under backpressure
    repeat (3) step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    repeat (4) step(4'hF, 1'b1);

    // burst-style: 1 and 2 both holding valid
    repeat (10) step(4'b0110, 1'b1);

    // mid-operation reset
    repeat (2) step(4'hF, 1'b0);
    do_reset();
    repeat (3) step(4'hF, 1'b1);

    rand_phase(200, 30, 70);
    rand_phase(200, 90, 50);
    rand_phase(200, 95, 95);
    do_reset();
    rand_phase(200, 60, 30);

    @(posedge clk);
    #1;
    model_update();
    drive(4'h0, 1'b0);
    @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    check("handshakes", 32'(hs_seen), 32'(hs_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
